// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Purpose: decouples core stores from the memory bus.
//   - Each store is legality-checked against its width and alignment.
//   - Legal stores are lane-formatted and queued in a DEPTH-entry FIFO.
//   - Illegal stores are dropped and reported with a one-cycle store_err pulse.
//   - The FIFO head is presented to memory with a valid/ready handshake.
//
// Ports:
//   clk          in   single clock; all state changes on its rising edge
//   reset        in   synchronous, active-high reset
//   mem_write_en in   store request from the core
//   s_type       in   store funct3 (000 SB, 001 SH, 010 SW)
//   mem_addr     in   byte address of the store
//   mem_wdata    in   right-aligned store data
//   stall        out  core must hold the current store (buffer full)
//   store_err    out  one-cycle pulse after a rejected store
//   bus_valid    out  head entry is presented to memory
//   bus_ready    in   memory accepts the head entry
//   bus_addr     out  word-aligned head address
//   bus_wdata    out  lane-replicated head data
//   bus_wstrb    out  head byte-lane strobes
//   count        out  number of valid entries
//   empty        out  high when no entries are held
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_write_en,
    input  logic [2:0]               s_type,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    output logic                     stall,
    output logic                     store_err,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [31:0]              bus_addr,
    output logic [31:0]              bus_wdata,
    output logic [3:0]               bus_wstrb,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage; only the word address is kept since bits [1:0] are
    // always zero on the bus.
    logic [29:0]   ent_addr_q  [DEPTH];
    logic [31:0]   ent_wdata_q [DEPTH];
    logic [3:0]    ent_wstrb_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          store_err_q, store_err_d;

    logic          legal;
    logic [3:0]    lane_strb;
    logic [31:0]   lane_data;
    logic          full;
    logic          is_empty;
    logic          accept;
    logic          dequeue;

    // Store decode: legality, byte strobes and lane replication.
    always_comb begin
        legal     = 1'b0;
        lane_strb = 4'b0000;
        lane_data = 32'h0;
        unique case (s_type)
            3'b000: begin
                legal     = 1'b1;
                lane_strb = 4'b0001 << mem_addr[1:0];
                lane_data = {4{mem_wdata[7:0]}};
            end
            3'b001: begin
                legal     = ~mem_addr[0];
                lane_strb = mem_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{mem_wdata[15:0]}};
            end
            3'b010: begin
                legal     = (mem_addr[1:0] == 2'b00);
                lane_strb = 4'b1111;
                lane_data = mem_wdata;
            end
            default: begin
                legal     = 1'b0;
            end
        endcase
    end

    assign full     = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // A full buffer never enqueues, even if the head drains this cycle;
    // this keeps stall independent of bus_ready. Illegal stores are
    // rejected rather than held, so they never stall.
    assign stall    = mem_write_en & legal & full;
    assign accept   = mem_write_en & legal & ~full;
    assign dequeue  = ~is_empty & bus_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        store_err_d = mem_write_en & ~legal;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (dequeue) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({accept, dequeue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            store_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            store_err_q <= store_err_d;
        end
    end

    // Payload RAM needs no reset: outputs are masked whenever the buffer
    // is empty, and a store coinciding with reset is dropped here.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            ent_addr_q[wr_ptr_q]  <= mem_addr[31:2];
            ent_wdata_q[wr_ptr_q] <= lane_data;
            ent_wstrb_q[wr_ptr_q] <= lane_strb;
        end
    end

    assign bus_valid = ~is_empty;
    assign bus_addr  = is_empty ? 32'h0 : {ent_addr_q[rd_ptr_q], 2'b00};
    assign bus_wdata = is_empty ? 32'h0 : ent_wdata_q[rd_ptr_q];
    assign bus_wstrb = is_empty ? 4'b0000 : ent_wstrb_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = is_empty;
    assign store_err = store_err_q;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write_en;
    logic [2:0]  s_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        store_err;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [2:0]  count;
    logic        empty;

    int tests = 0;
    int fails = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_write_en (mem_write_en),
        .s_type       (s_type),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .stall        (stall),
        .store_err    (store_err),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .count        (count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and samples sit 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_sw(input logic [31:0] a);
        mem_write_en = 1'b1;
        s_type       = 3'b010;
        mem_addr     = a;
        mem_wdata    = a ^ 32'h5A5A0000;
        tick();
        mem_write_en = 1'b0;
    endtask

    logic [31:0] exp_head;

    initial begin
        reset        = 1'b1;
        mem_write_en = 1'b0;
        s_type       = 3'b000;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        bus_ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_wstrb", 32'(bus_wstrb), 32'h0);
        check("rst_err", 32'(store_err), 32'd0);

        // SB at 0x103, ready held high
        bus_ready    = 1'b1;
        mem_write_en = 1'b1;
        s_type       = 3'b000;
        mem_addr     = 32'h103;
        mem_wdata    = 32'hAABBCCDD;
        check("sb_stall", 32'(stall), 32'd0);
        check("sb_no_bypass", 32'(bus_valid), 32'd0);
        tick();
        mem_write_en = 1'b0;
        check("sb_valid", 32'(bus_valid), 32'd1);
        check("sb_addr", bus_addr, 32'h100);
        check("sb_wstrb", 32'(bus_wstrb), 32'b1000);
        check("sb_wdata", bus_wdata, 32'hDDDDDDDD);
        tick();
        check("sb_drained", 32'(empty), 32'd1);
        check("sb_idle_addr", bus_addr, 32'h0);

        // SH at 0x202, then misaligned SH at 0x201
        bus_ready    = 1'b0;
        mem_write_en = 1'b1;
        s_type       = 3'b001;
        mem_addr     = 32'h202;
        mem_wdata    = 32'h00001234;
        tick();
        mem_addr     = 32'h201;
        check("sh_addr", bus_addr, 32'h200);
        check("sh_wstrb", 32'(bus_wstrb), 32'b1100);
        check("sh_wdata", bus_wdata, 32'h12341234);
        check("sh_bad_stall", 32'(stall), 32'd0);
        tick();
        mem_write_en = 1'b0;
        check("sh_bad_err", 32'(store_err), 32'd1);
        check("sh_bad_count", 32'(count), 32'd1);
        tick();
        check("sh_err_one_cycle", 32'(store_err), 32'd0);
        bus_ready = 1'b1;
        tick();
        check("sh_drained", 32'(empty), 32'd1);

        // SB lane 0 and SH low half
        bus_ready    = 1'b0;
        mem_write_en = 1'b1;
        s_type       = 3'b000;
        mem_addr     = 32'h40;
        mem_wdata    = 32'h000000A5;
        tick();
        s_type       = 3'b001;
        mem_addr     = 32'h44;
        mem_wdata    = 32'hFFFF9876;
        tick();
        mem_write_en = 1'b0;
        check("sb0_wstrb", 32'(bus_wstrb), 32'b0001);
        check("sb0_wdata", bus_wdata, 32'hA5A5A5A5);
        bus_ready = 1'b1;
        tick();
        check("shlo_wstrb", 32'(bus_wstrb), 32'b0011);
        check("shlo_wdata", bus_wdata, 32'h98769876);
        tick();
        check("lanes_drained", 32'(empty), 32'd1);

        // Fill with ready low, fifth store stalls
        bus_ready = 1'b0;
        put_sw(32'h0);
        put_sw(32'h4);
        put_sw(32'h8);
        put_sw(32'hC);
        check("fill_count", 32'(count), 32'd4);
        mem_write_en = 1'b1;
        s_type       = 3'b010;
        mem_addr     = 32'h10;
        mem_wdata    = 32'h10 ^ 32'h5A5A0000;
        check("fill_stall", 32'(stall), 32'd1);
        tick();
        check("fill_hold_count", 32'(count), 32'd4);
        check("fill_hold_stall", 32'(stall), 32'd1);
        check("fill_head_stable", bus_addr, 32'h0);
        // Full and draining: the fifth store is still refused on this edge.
        bus_ready = 1'b1;
        check("fill_stall_ready", 32'(stall), 32'd1);
        tick();
        check("drain0_count", 32'(count), 32'd3);
        check("drain_head1", bus_addr, 32'h4);
        check("drain_stall_low", 32'(stall), 32'd0);
        tick();
        mem_write_en = 1'b0;
        check("drain1_count", 32'(count), 32'd3);
        check("drain_head2", bus_addr, 32'h8);
        tick();
        check("drain_head3", bus_addr, 32'hC);
        check("drain_head3_data", bus_wdata, 32'h5A5A000C);
        tick();
        check("drain_head4", bus_addr, 32'h10);
        check("drain2_count", 32'(count), 32'd1);
        tick();
        check("fill_drained", 32'(empty), 32'd1);

        // Concurrent enqueue/dequeue with two entries held
        bus_ready = 1'b0;
        put_sw(32'h1000);
        put_sw(32'h1004);
        check("conc_start", 32'(count), 32'd2);
        bus_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      exp_head = 32'h1000;
            else if (i == 1) exp_head = 32'h1004;
            else             exp_head = 32'h2000 + 32'(4 * (i - 2));
            check("conc_head", bus_addr, exp_head);
            mem_write_en = 1'b1;
            s_type       = 3'b010;
            mem_addr     = 32'h2000 + 32'(4 * i);
            mem_wdata    = 32'h0;
            tick();
            check("conc_count", 32'(count), 32'd2);
        end
        mem_write_en = 1'b0;
        check("conc_tail0", bus_addr, 32'h2020);
        tick();
        check("conc_tail1", bus_addr, 32'h2024);
        tick();
        check("conc_drained", 32'(empty), 32'd1);

        // Reset with three pending entries, plus a store in the reset cycle
        bus_ready = 1'b0;
        put_sw(32'h3000);
        put_sw(32'h3004);
        put_sw(32'h3008);
        check("prerst_count", 32'(count), 32'd3);
        reset        = 1'b1;
        bus_ready    = 1'b1;
        mem_write_en = 1'b1;
        s_type       = 3'b010;
        mem_addr     = 32'h4000;
        tick();
        reset        = 1'b0;
        mem_write_en = 1'b0;
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_valid", 32'(bus_valid), 32'd0);
        check("rst2_empty", 32'(empty), 32'd1);
        tick();
        tick();
        check("rst2_no_stale", 32'(bus_valid), 32'd0);
        check("rst2_addr", bus_addr, 32'h0);

        // Illegal s_type and misaligned SW
        bus_ready    = 1'b0;
        mem_write_en = 1'b1;
        s_type       = 3'b011;
        mem_addr     = 32'h500;
        check("ill_type_stall", 32'(stall), 32'd0);
        tick();
        mem_write_en = 1'b0;
        check("ill_type_err", 32'(store_err), 32'd1);
        check("ill_type_count", 32'(count), 32'd0);
        tick();
        check("ill_type_err_low", 32'(store_err), 32'd0);
        mem_write_en = 1'b1;
        s_type       = 3'b010;
        mem_addr     = 32'h6;
        check("ill_sw_stall", 32'(stall), 32'd0);
        tick();
        mem_write_en = 1'b0;
        check("ill_sw_err", 32'(store_err), 32'd1);
        check("ill_sw_empty", 32'(empty), 32'd1);
        tick();
        check("ill_sw_err_low", 32'(store_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered store entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port mem_write_en, input, 1 bit: store request from the core.
REQ-005 The block SHALL have port s_type, input, 3 bits: store funct3 (000 SB, 001 SH, 010 SW).
REQ-006 The block SHALL have port mem_addr, input, 32 bits: byte address (core ALU result).
REQ-007 The block SHALL have port mem_wdata, input, 32 bits: store data, right-aligned (rs2).
REQ-008 The block SHALL have port stall, output, 1 bit: the core must hold the current store.
REQ-009 The block SHALL have port store_err, output, 1 bit: one-cycle pulse for a rejected store.
REQ-010 The block SHALL have port bus_valid, output, 1 bit: the head entry is presented to memory.
REQ-011 The block SHALL have port bus_ready, input, 1 bit: memory accepts the head entry.
REQ-012 The block SHALL have port bus_addr, output, 32 bits: word-aligned address, bits [1:0] always 00.
REQ-013 The block SHALL have port bus_wdata, output, 32 bits: lane-replicated write data.
REQ-014 The block SHALL have port bus_wstrb, output, 4 bits: byte-lane write strobes.
REQ-015 The block SHALL have port count, output, clog2(DEPTH)+1 bits: number of valid entries.
REQ-016 The block SHALL have port empty, output, 1 bit: high when count is 0.

Function
REQ-017 Accept condition SHALL be mem_write_en high, count less than DEPTH, and a legal store; the entry is written at the clk edge.
REQ-018 stall SHALL be combinational: high when mem_write_en is high and count equals DEPTH, independent of bus_ready; a full buffer never enqueues, even when it dequeues in the same cycle.
REQ-019 SB handling SHALL be: wstrb = 0001 shifted left by addr[1:0]; wdata = mem_wdata[7:0] replicated 4 times.
REQ-020 SH handling SHALL require addr[0] = 0: wstrb = 0011 if addr[1] = 0, else 1100; wdata = mem_wdata[15:0] replicated 2 times.
REQ-021 SW handling SHALL require addr[1:0] = 00: wstrb = 1111; wdata = mem_wdata.
REQ-022 Illegal stores SHALL be: misaligned SH or SW, or any s_type other than 000, 001 or 010.
  - An illegal store is not enqueued and does not assert stall.
  - store_err is high for exactly the following cycle.
REQ-023 bus_addr SHALL be {mem_addr[31:2], 00} as captured at enqueue.
REQ-024 bus_valid SHALL equal not empty; bus_addr, bus_wdata and bus_wstrb SHALL present the head entry.
REQ-025 Head signals SHALL stay stable while bus_valid is high and bus_ready is low.
REQ-026 Dequeue SHALL occur at an edge where bus_valid and bus_ready are both high; bus_ready is ignored while empty.
REQ-027 Latency SHALL be: a store accepted into an empty buffer at edge N gives bus_valid high after edge N; there is no same-cycle bypass.
REQ-028 Simultaneous enqueue and dequeue (count less than DEPTH) SHALL leave count unchanged and advance both pointers.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; entries drain in strict FIFO order.
REQ-030 Idle outputs (empty) SHALL be: bus_addr, bus_wdata and bus_wstrb all zero.
REQ-031 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-032 While reset is high at a clk edge, the block SHALL clear count, both pointers and store_err; bus_valid = 0, bus_wstrb = 0000, bus_addr = 0, bus_wdata = 0, empty = 1.
REQ-033 Reset during operation SHALL discard all buffered entries, with no bus transfer completing at that edge.
REQ-034 A store presented in the same cycle as reset SHALL be dropped.

Verification
REQ-035 SB test SHALL apply addr 0x103, wdata 0xAABBCCDD, bus_ready 1 -> next cycle: bus_addr 0x100, wstrb 1000, wdata 0xDDDDDDDD; one cycle later empty.
REQ-036 SH test SHALL apply addr 0x202, wdata 0x1234 -> wstrb 1100, wdata 0x12341234; SH at 0x201 -> store_err pulses 1 cycle, count unchanged.
REQ-037 Fill test SHALL hold bus_ready 0 and issue 5 SW (0x0, 0x4, ... 0x10).
  - count reaches 4.
  - stall is high on the 5th store.
  - Raising bus_ready drains entries in order 0x0, 0x4, 0x8, 0xC, then the 5th store is accepted.
REQ-038 Concurrent test SHALL, with count 2 and bus_ready 1, issue an SW each cycle for 10 cycles -> count stays 2, and the pointers wrap correctly.
REQ-039 Reset test SHALL assert reset with 3 entries pending -> next cycle: count 0, bus_valid 0, and no stale entry appears afterward.
REQ-040 Illegal s_type test SHALL apply s_type 011 or SW at addr 0x6 -> store_err pulses, nothing enqueued, stall stays 0.
